// File: rtl/acc_cpu_core.sv
// ----------------------------------------------------------------------------
// acc_cpu_core
//
// Parametrised accumulator CPU core. A unified program/data RAM is filled
// through the program port while prog_en is high. A pulse on run then starts
// execution from address 0. Each instruction takes three cycles:
// FETCH, DECODE (operand read) and EXEC.
//
// Parameters
//   DATA_W     accumulator / memory word / output width (>= ADDR_W+4)
//   ADDR_W     memory address width, depth is 2**ADDR_W words
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   prog_en    program mode, forces the core back to IDLE
//   prog_we    memory write strobe, honoured only while prog_en=1
//   prog_addr  program write address
//   prog_data  program write data
//   run        start execution from PC=0, sampled only in IDLE
//   out_data   registered value written by OUT
//   out_valid  one-cycle pulse when out_data is updated
//   halted     high while in HALT
//   busy       high in FETCH, DECODE or EXEC
// ----------------------------------------------------------------------------
module acc_cpu_core #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              prog_en,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data,
    input  logic              run,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              halted,
    output logic              busy
);

    localparam int DEPTH = 1 << ADDR_W;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'h9;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_HALT
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic [DATA_W-1:0] mdr_q, mdr_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic              z_q, z_d;
    logic              c_q, c_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic              halted_q, halted_d;
    logic              busy_q, busy_d;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    logic [3:0]        opcode;
    logic [ADDR_W-1:0] operand;
    logic [DATA_W:0]   add_res;
    logic [DATA_W:0]   sub_res;

    // Next-state and datapath logic. Program mode overrides every state so
    // that an in-flight instruction (including a STA) is simply dropped.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        mdr_d       = mdr_q;
        a_d         = a_q;
        z_d         = z_q;
        c_d         = c_q;
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;
        mem_we      = 1'b0;
        mem_waddr   = prog_addr;
        mem_wdata   = prog_data;

        opcode  = ir_q[ADDR_W+3:ADDR_W];
        operand = ir_q[ADDR_W-1:0];
        add_res = {1'b0, a_q} + {1'b0, mdr_q};
        sub_res = {1'b0, a_q} - {1'b0, mdr_q};

        if (prog_en) begin
            state_d = S_IDLE;
            pc_d    = '0;
            a_d     = '0;
            z_d     = 1'b0;
            c_d     = 1'b0;
            mem_we  = prog_we;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (run) begin
                        state_d = S_FETCH;
                        pc_d    = '0;
                    end
                end
                S_FETCH: begin
                    ir_d    = mem[pc_q];
                    // PC width equals the address width, so it wraps naturally
                    pc_d    = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                    state_d = S_DECODE;
                end
                S_DECODE: begin
                    mdr_d   = mem[operand];
                    state_d = S_EXEC;
                end
                S_EXEC: begin
                    state_d = S_FETCH;
                    case (opcode)
                        OP_LDA: begin
                            a_d = mdr_q;
                            z_d = (mdr_q == '0);
                        end
                        OP_ADD: begin
                            a_d = add_res[DATA_W-1:0];
                            z_d = (add_res[DATA_W-1:0] == '0);
                            c_d = add_res[DATA_W];
                        end
                        OP_SUB: begin
                            a_d = sub_res[DATA_W-1:0];
                            z_d = (sub_res[DATA_W-1:0] == '0);
                            // borrow shows up in the extra MSB; carry means no borrow
                            c_d = ~sub_res[DATA_W];
                        end
                        OP_STA: begin
                            mem_we    = 1'b1;
                            mem_waddr = operand;
                            mem_wdata = a_q;
                        end
                        OP_LDI: begin
                            a_d = DATA_W'(operand);
                            z_d = (operand == '0);
                        end
                        OP_JMP: pc_d = operand;
                        OP_JC:  if (c_q) pc_d = operand;
                        OP_JZ:  if (z_q) pc_d = operand;
                        OP_OUT: begin
                            out_data_d  = a_q;
                            out_valid_d = 1'b1;
                        end
                        OP_HLT: state_d = S_HALT;
                        default: ;
                    endcase
                end
                S_HALT: state_d = S_HALT;
                default: state_d = S_IDLE;
            endcase
        end

        halted_d = (state_d == S_HALT);
        busy_d   = (state_d == S_FETCH) || (state_d == S_DECODE) || (state_d == S_EXEC);
    end

    // Core registers and FSM state; status outputs are registered from the
    // next state so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            pc_q        <= '0;
            ir_q        <= '0;
            mdr_q       <= '0;
            a_q         <= '0;
            z_q         <= 1'b0;
            c_q         <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            halted_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            mdr_q       <= mdr_d;
            a_q         <= a_d;
            z_q         <= z_d;
            c_q         <= c_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            halted_q    <= halted_d;
            busy_q      <= busy_d;
        end
    end

    // Single write port; memory contents survive reset, but a write that
    // coincides with reset is dropped.
    always_ff @(posedge clk) begin
        if (!rst && mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign halted    = halted_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_acc_cpu_core.sv
// ----------------------------------------------------------------------------
// tb_acc_cpu_core
//
// Directed bench for acc_cpu_core. One instance uses the default 8/4
// geometry and a second uses DATA_W=12, ADDR_W=6. Inputs change and outputs
// are sampled on the falling clock edge. "After edge k" means the falling
// edge that follows rising edge k, where edge 0 samples run.
// ----------------------------------------------------------------------------
module tb_acc_cpu_core;

    logic        clk;
    logic        rst;

    logic        prog_en,  prog_we,  run;
    logic [3:0]  prog_addr;
    logic [7:0]  prog_data;
    logic [7:0]  out_data;
    logic        out_valid, halted, busy;

    logic        prog_en2, prog_we2, run2;
    logic [5:0]  prog_addr2;
    logic [11:0] prog_data2;
    logic [11:0] out_data2;
    logic        out_valid2, halted2, busy2;

    int vectors;
    int miscompares;
    int pulses;

    acc_cpu_core #(.DATA_W(8), .ADDR_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .prog_en   (prog_en),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .run       (run),
        .out_data  (out_data),
        .out_valid (out_valid),
        .halted    (halted),
        .busy      (busy)
    );

    acc_cpu_core #(.DATA_W(12), .ADDR_W(6)) dut2 (
        .clk       (clk),
        .rst       (rst),
        .prog_en   (prog_en2),
        .prog_we   (prog_we2),
        .prog_addr (prog_addr2),
        .prog_data (prog_data2),
        .run       (run2),
        .out_data  (out_data2),
        .out_valid (out_valid2),
        .halted    (halted2),
        .busy      (busy2)
    );

    // 10 ns clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare one observed value with its hand-computed expectation.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Write one memory word through the program port of the selected core.
    // prog_en stays high afterwards until releaseProg is called.
    task automatic applyStimulus(input int which, input int addr, input int data);
        if (which == 1) begin
            prog_en   = 1'b1;
            prog_we   = 1'b1;
            prog_addr = 4'(addr);
            prog_data = 8'(data);
        end else begin
            prog_en2   = 1'b1;
            prog_we2   = 1'b1;
            prog_addr2 = 6'(addr);
            prog_data2 = 12'(data);
        end
        @(negedge clk);
        prog_we  = 1'b0;
        prog_we2 = 1'b0;
    endtask

    // Leave program mode; the core sits in IDLE afterwards.
    task automatic releaseProg(input int which);
        if (which == 1) prog_en = 1'b0;
        else prog_en2 = 1'b0;
        @(negedge clk);
    endtask

    // Raise run for one rising edge (edge 0); returns just after edge 0.
    task automatic startRun(input int which);
        pulses = 0;
        if (which == 1) run = 1'b1;
        else run2 = 1'b1;
        @(negedge clk);
        run  = 1'b0;
        run2 = 1'b0;
    endtask

    // Advance n rising edges, counting out_valid pulses on the way.
    task automatic waitEdges(input int which, input int n);
        repeat (n) begin
            @(negedge clk);
            if ((which == 1) ? out_valid : out_valid2) pulses++;
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        pulses      = 0;
        rst         = 1'b1;
        prog_en     = 1'b0;
        prog_we     = 1'b0;
        run         = 1'b0;
        prog_addr   = '0;
        prog_data   = '0;
        prog_en2    = 1'b0;
        prog_we2    = 1'b0;
        run2        = 1'b0;
        prog_addr2  = '0;
        prog_data2  = '0;

        // Reset state
        repeat (3) @(negedge clk);
        checkOutput("rst_out_data",  32'(out_data),  32'h0);
        checkOutput("rst_out_valid", 32'(out_valid), 32'h0);
        checkOutput("rst_halted",    32'(halted),    32'h0);
        checkOutput("rst_busy",      32'(busy),      32'h0);
        checkOutput("rst_pc",        32'(dut.pc_q),  32'h0);
        checkOutput("rst_a",         32'(dut.a_q),   32'h0);
        checkOutput("rst2_busy",     32'(busy2),     32'h0);
        rst = 1'b0;
        @(negedge clk);

        // Basic add: LDA 14, ADD 15, OUT, HLT with 5 + 7
        applyStimulus(1, 0, 'h1E);
        applyStimulus(1, 1, 'h2F);
        applyStimulus(1, 2, 'h90);
        applyStimulus(1, 3, 'hF0);
        applyStimulus(1, 14, 'h05);
        applyStimulus(1, 15, 'h07);
        releaseProg(1);
        startRun(1);
        checkOutput("add_busy_e0", 32'(busy), 32'h1);
        waitEdges(1, 8);
        checkOutput("add_valid_e8", 32'(out_valid), 32'h0);
        waitEdges(1, 1);
        checkOutput("add_valid_e9", 32'(out_valid), 32'h1);
        checkOutput("add_data_e9",  32'(out_data),  32'h0C);
        waitEdges(1, 1);
        checkOutput("add_valid_e10", 32'(out_valid), 32'h0);
        checkOutput("add_data_e10",  32'(out_data),  32'h0C);
        waitEdges(1, 1);
        checkOutput("add_halted_e11", 32'(halted), 32'h0);
        waitEdges(1, 1);
        checkOutput("add_halted_e12", 32'(halted), 32'h1);
        checkOutput("add_busy_e12",   32'(busy),   32'h0);
        // run held high in HALT must not restart
        run = 1'b1;
        waitEdges(1, 4);
        run = 1'b0;
        checkOutput("halt_run_halted", 32'(halted), 32'h1);
        checkOutput("halt_run_busy",   32'(busy),   32'h0);
        checkOutput("add_pulses",      32'(pulses), 32'h1);

        // Carry/zero: 0xFF + 0x01 -> 0, JC taken to LDI 3 / OUT
        applyStimulus(1, 0, 'h1E);
        applyStimulus(1, 1, 'h2F);
        applyStimulus(1, 2, 'h75);
        applyStimulus(1, 3, 'h90);
        applyStimulus(1, 4, 'hF0);
        applyStimulus(1, 5, 'h53);
        applyStimulus(1, 6, 'h90);
        applyStimulus(1, 7, 'hF0);
        applyStimulus(1, 14, 'hFF);
        applyStimulus(1, 15, 'h01);
        checkOutput("prog_idle_halted", 32'(halted), 32'h0);
        releaseProg(1);
        startRun(1);
        waitEdges(1, 3);
        checkOutput("cz_lda_a", 32'(dut.a_q), 32'hFF);
        checkOutput("cz_lda_z", 32'(dut.z_q), 32'h0);
        waitEdges(1, 3);
        checkOutput("cz_add_a", 32'(dut.a_q), 32'h00);
        checkOutput("cz_add_z", 32'(dut.z_q), 32'h1);
        checkOutput("cz_add_c", 32'(dut.c_q), 32'h1);
        waitEdges(1, 3);
        checkOutput("cz_jc_pc", 32'(dut.pc_q), 32'h5);
        waitEdges(1, 6);
        checkOutput("cz_out_valid", 32'(out_valid), 32'h1);
        checkOutput("cz_out_data",  32'(out_data),  32'h03);
        waitEdges(1, 3);
        checkOutput("cz_halted", 32'(halted), 32'h1);
        checkOutput("cz_pulses", 32'(pulses), 32'h1);

        // Borrow: 3 - 5 -> 0xFE, C=0, Z=0, neither branch taken
        applyStimulus(1, 0, 'h53);
        applyStimulus(1, 1, 'h3E);
        applyStimulus(1, 2, 'h87);
        applyStimulus(1, 3, 'h77);
        applyStimulus(1, 4, 'h90);
        applyStimulus(1, 5, 'hF0);
        applyStimulus(1, 7, 'hF0);
        applyStimulus(1, 14, 'h05);
        releaseProg(1);
        startRun(1);
        waitEdges(1, 6);
        checkOutput("sub_a", 32'(dut.a_q), 32'hFE);
        checkOutput("sub_c", 32'(dut.c_q), 32'h0);
        checkOutput("sub_z", 32'(dut.z_q), 32'h0);
        waitEdges(1, 3);
        checkOutput("sub_jz_pc", 32'(dut.pc_q), 32'h3);
        waitEdges(1, 3);
        checkOutput("sub_jc_pc", 32'(dut.pc_q), 32'h4);
        waitEdges(1, 3);
        checkOutput("sub_out_valid", 32'(out_valid), 32'h1);
        checkOutput("sub_out_data",  32'(out_data),  32'hFE);
        waitEdges(1, 3);
        checkOutput("sub_halted", 32'(halted), 32'h1);

        // Store and PC wrap
        applyStimulus(1, 0, 'h1C);
        applyStimulus(1, 1, 'h4D);
        applyStimulus(1, 2, 'h50);
        applyStimulus(1, 3, 'h1D);
        applyStimulus(1, 4, 'h90);
        applyStimulus(1, 5, 'h50);
        applyStimulus(1, 6, 'h6F);
        applyStimulus(1, 12, 'h5A);
        applyStimulus(1, 13, 'h00);
        applyStimulus(1, 15, 'h00);
        releaseProg(1);
        startRun(1);
        waitEdges(1, 6);
        checkOutput("sta_mem13", 32'(dut.mem[13]), 32'h5A);
        waitEdges(1, 3);
        checkOutput("sta_ldi0_a", 32'(dut.a_q), 32'h00);
        checkOutput("sta_ldi0_z", 32'(dut.z_q), 32'h1);
        waitEdges(1, 6);
        checkOutput("sta_out_valid", 32'(out_valid), 32'h1);
        checkOutput("sta_out_data",  32'(out_data),  32'h5A);
        waitEdges(1, 6);
        checkOutput("wrap_jmp_pc", 32'(dut.pc_q), 32'hF);
        waitEdges(1, 1);
        checkOutput("wrap_pc0", 32'(dut.pc_q), 32'h0);
        waitEdges(1, 2);
        checkOutput("wrap_a_before", 32'(dut.a_q), 32'h00);
        waitEdges(1, 3);
        checkOutput("wrap_reexec_a", 32'(dut.a_q), 32'h5A);

        // Abort: prog_en lands on the EXEC edge of STA 13
        applyStimulus(1, 0, 'h57);
        applyStimulus(1, 1, 'h4D);
        applyStimulus(1, 2, 'hF0);
        applyStimulus(1, 13, 'h33);
        releaseProg(1);
        startRun(1);
        waitEdges(1, 3);
        checkOutput("abort_ldi_a", 32'(dut.a_q), 32'h07);
        waitEdges(1, 2);
        prog_en = 1'b1;
        @(negedge clk);
        checkOutput("abort_mem13",  32'(dut.mem[13]), 32'h33);
        checkOutput("abort_pc",     32'(dut.pc_q),    32'h0);
        checkOutput("abort_a",      32'(dut.a_q),     32'h0);
        checkOutput("abort_busy",   32'(busy),        32'h0);
        checkOutput("abort_halted", 32'(halted),      32'h0);
        checkOutput("abort_outkeep", 32'(out_data),   32'h5A);

        // Reset during FETCH
        applyStimulus(1, 0, 'h59);
        applyStimulus(1, 1, 'h90);
        applyStimulus(1, 2, 'hF0);
        releaseProg(1);
        startRun(1);
        waitEdges(1, 6);
        checkOutput("rstf_out_data", 32'(out_data), 32'h09);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rstf_out_data0", 32'(out_data),  32'h0);
        checkOutput("rstf_valid",     32'(out_valid), 32'h0);
        checkOutput("rstf_halted",    32'(halted),    32'h0);
        checkOutput("rstf_busy",      32'(busy),      32'h0);
        checkOutput("rstf_pc",        32'(dut.pc_q),  32'h0);
        checkOutput("rstf_a",         32'(dut.a_q),   32'h0);
        rst = 1'b0;
        @(negedge clk);

        // Wide core: LDI 1 + 0xFFF -> 0, C=1
        applyStimulus(2, 0, 'h141);
        applyStimulus(2, 1, 'h0BF);
        applyStimulus(2, 2, 'h240);
        applyStimulus(2, 3, 'h3C0);
        applyStimulus(2, 63, 'hFFF);
        releaseProg(2);
        startRun(2);
        waitEdges(2, 3);
        checkOutput("w_ldi_a", 32'(dut2.a_q), 32'h001);
        waitEdges(2, 3);
        checkOutput("w_add_a", 32'(dut2.a_q), 32'h000);
        checkOutput("w_add_c", 32'(dut2.c_q), 32'h1);
        checkOutput("w_add_z", 32'(dut2.z_q), 32'h1);
        waitEdges(2, 3);
        checkOutput("w_out_valid", 32'(out_valid2), 32'h1);
        checkOutput("w_out_data",  32'(out_data2),  32'h000);
        waitEdges(2, 3);
        checkOutput("w_halted", 32'(halted2), 32'h1);

        // Wide core: code at 60..63 wraps back to 0
        applyStimulus(2, 0, 'h1BC);
        applyStimulus(2, 60, 'h145);
        applyStimulus(2, 61, 'h240);
        applyStimulus(2, 62, 'h000);
        applyStimulus(2, 63, 'h000);
        releaseProg(2);
        startRun(2);
        waitEdges(2, 3);
        checkOutput("w_jmp_pc", 32'(dut2.pc_q), 32'd60);
        waitEdges(2, 6);
        checkOutput("w2_out_valid", 32'(out_valid2), 32'h1);
        checkOutput("w2_out_data",  32'(out_data2),  32'h005);
        waitEdges(2, 4);
        checkOutput("w_wrap_pc0", 32'(dut2.pc_q), 32'h0);
        waitEdges(2, 5);
        checkOutput("w_rejmp_pc", 32'(dut2.pc_q), 32'd60);
        prog_en2 = 1'b1;
        @(negedge clk);
        checkOutput("w_abort_busy", 32'(busy2), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
